// File: rtl/mem_stage_if.sv
// Request/response bundle between the control unit and the memory-access stage.
interface mem_stage_if;
  logic        Mem_req;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic        Mem_WrEn;
  logic        ByteOp;
  logic [31:0] MEM_DataOut;
  logic        Mem_busy;
  logic        Mem_done;
  logic        Addr_err;

  // The requester drives the access and watches the handshake.
  modport master (
    output Mem_req, ALU_MEM_Addr, MEM_DataIn, Mem_WrEn, ByteOp,
    input  MEM_DataOut, Mem_busy, Mem_done, Addr_err
  );

  // The memory stage consumes the access and reports completion.
  modport slave (
    input  Mem_req, ALU_MEM_Addr, MEM_DataIn, Mem_WrEn, ByteOp,
    output MEM_DataOut, Mem_busy, Mem_done, Addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word/byte loads and stores on an internal data memory
// with a fixed number of wait states and a req/busy/done handshake.
module mem_stage #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] ADDR_OFFSET = 32'h0000_0400,
  parameter int          WAIT_CYCLES = 2
) (
  input logic        Clk,
  input logic        Reset_n,
  mem_stage_if.slave bus
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              byte_q;
  logic [31:0]       dataOut_q;
  logic              busy_q;
  logic              done_q;
  logic              addrErr_q;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       effIn;
  logic [29:0]       idxIn;
  logic              errIn;
  logic [31:0]       rdWord;
  logic [31:0]       mergedWord;
  logic [31:0]       loadVal;
  logic              accessNow;

  // Decode the incoming request: effective address, word index and error check.
  always_comb begin
    effIn = bus.ALU_MEM_Addr + ADDR_OFFSET;
    idxIn = effIn[31:2];
    errIn = ({2'b00, idxIn} >= 32'(DEPTH)) ||
            (!bus.ByteOp && (effIn[1:0] != 2'b00));
  end

  // Build the byte-merged store word and the (possibly zero-extended) load value.
  always_comb begin
    rdWord     = mem[idx_q];
    accessNow  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    mergedWord = wdata_q;
    loadVal    = rdWord;
    if (byte_q) begin
      mergedWord = rdWord;
      case (lane_q)
        2'd0: begin
          mergedWord[7:0] = wdata_q[7:0];
          loadVal         = {24'b0, rdWord[7:0]};
        end
        2'd1: begin
          mergedWord[15:8] = wdata_q[7:0];
          loadVal          = {24'b0, rdWord[15:8]};
        end
        2'd2: begin
          mergedWord[23:16] = wdata_q[7:0];
          loadVal           = {24'b0, rdWord[23:16]};
        end
        default: begin
          mergedWord[31:24] = wdata_q[7:0];
          loadVal           = {24'b0, rdWord[31:24]};
        end
      endcase
    end
  end

  // Memory write port; reset forces IDLE so an in-flight store is dropped.
  always_ff @(posedge Clk) begin
    if (accessNow && wr_q) begin
      mem[idx_q] <= mergedWord;
    end
  end

  // Control FSM with registered handshake outputs and load-result register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      lane_q    <= 2'd0;
      wdata_q   <= 32'd0;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      dataOut_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addrErr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q    <= 1'b0;
          addrErr_q <= 1'b0;
          if (bus.Mem_req) begin
            idx_q   <= idxIn[IDXW-1:0];
            lane_q  <= effIn[1:0];
            wdata_q <= bus.MEM_DataIn;
            wr_q    <= bus.Mem_WrEn;
            byte_q  <= bus.ByteOp;
            busy_q  <= 1'b1;
            if (errIn) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              addrErr_q <= 1'b1;
              dataOut_q <= 32'd0;
            end else begin
              cnt_q   <= 4'(WAIT_CYCLES);
              state_q <= ST_WAIT;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_q) begin
              dataOut_q <= loadVal;
            end
            done_q    <= 1'b1;
            addrErr_q <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q    <= 1'b0;
          addrErr_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_DataOut = dataOut_q;
  assign bus.Mem_busy    = busy_q;
  assign bus.Mem_done    = done_q;
  assign bus.Addr_err    = addrErr_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU stage.
- Consumes the ALU result as a data-memory address and the register-file B operand as store data.
- Performs word or byte loads/stores on an internal data memory with a configurable wait-state latency.
- Exposes a request/busy/done handshake so the control unit can stall the datapath during multi-cycle accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory.
- ADDR_OFFSET, 32'h0000_0400, constant added to ALU_MEM_Addr to form the effective address.
- WAIT_CYCLES, 2, extra wait states per access (legal 0..15).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Mem_req  in  1  access request; sampled only in IDLE.
- ALU_MEM_Addr  in  32  address from ALU_out.
- MEM_DataIn  in  32  store data (RF_B).
- Mem_WrEn  in  1  1 = store, 0 = load.
- ByteOp  in  1  1 = byte access, 0 = word access.
- MEM_DataOut  out  32  load result.
- Mem_busy  out  1  high whenever state is not IDLE.
- Mem_done  out  1  one-cycle completion pulse.
- Addr_err  out  1  error flag for the completed transaction; valid while Mem_done=1.

Behaviour:
- Effective address: eff = ALU_MEM_Addr + ADDR_OFFSET, modulo 2^32. Word index = eff[31:2]. Byte lane = eff[1:0], little-endian (lane 0 = bits 7:0).
- Error conditions:
  - index >= DEPTH;
  - word access (ByteOp=0) with eff[1:0] != 0.
  - On error: no memory write occurs, MEM_DataOut is set to 0, Addr_err=1 with Mem_done.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Mem_busy=0, Mem_done=0.
  - On an edge with Mem_req=1: capture eff, MEM_DataIn, Mem_WrEn and ByteOp into internal registers.
  - If the captured request is erroneous, go to DONE.
  - Otherwise load the counter with WAIT_CYCLES and go to WAIT.
  - Mem_req=0: stay in IDLE.
- WAIT:
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0: perform the access and go to DONE.
- Access rules (all on the single completing edge):
  - Word store: writes all 32 bits.
  - Byte store: read-modify-write; only the selected lane is replaced with MEM_DataIn[7:0], the other three bytes are unchanged.
  - Word load: MEM_DataOut = mem[index].
  - Byte load: MEM_DataOut = zero-extended selected byte.
  - Stores leave MEM_DataOut unchanged.
- DONE:
  - Mem_done=1, Mem_busy=1 for exactly one cycle, then return to IDLE unconditionally.
  - Mem_req is ignored in DONE and in WAIT; inputs may change freely there because they were captured.
- Latency: capture edge = E0; Mem_done is high in the cycle after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: done after E1.
  - Error path: done after E0 regardless of WAIT_CYCLES.
- Back-to-back: Mem_req still high in the IDLE cycle after DONE starts a new transaction. The requester must drop Mem_req after Mem_done for single accesses.
- MEM_DataOut holds its value until the next load or error completion.
- Reset (async, any state):
  - state=IDLE, counter=0.
  - MEM_DataOut=0, Mem_busy=0, Mem_done=0, Addr_err=0.
  - Memory array contents are not reset.
  - A store in WAIT when reset asserts is discarded (no write), and no Mem_done is produced.
- Addr_err is 0 outside the DONE cycle.

Test Plan:
- Word store/load, WAIT_CYCLES=2:
  - Stimulus: store 32'hDEADBEEF at ALU_MEM_Addr=0x8 (eff 0x408, index 258), then load the same address.
  - Required: Mem_busy high for 4 cycles per access; Mem_done high one cycle after E3; MEM_DataOut=32'hDEADBEEF; Addr_err=0.
- Byte read-modify-write:
  - Stimulus: word 32'h11223344 at addr 0x10; byte store 8'hAA at addr 0x11; word load at 0x10.
  - Required: MEM_DataOut=32'h1122AA44. A byte load at 0x13 returns 32'h00000011.
- Errors:
  - Word load at addr 0x6 (misaligned): Mem_done after E0, Addr_err=1, MEM_DataOut=0.
  - Word store at addr 0x1000 (index 1280 >= 1024): Addr_err=1, and a later load of the memory word at index 1280 mod 1024 (index 256, ALU_MEM_Addr=0x0) is unchanged.
- Handshake:
  - Mem_req held high through DONE with a new address applied mid-WAIT: first access uses the captured address; the second transaction starts in the IDLE cycle after DONE.
  - Mem_done pulses are exactly one cycle each.
- Reset mid-operation:
  - Stimulus: store 32'hCAFEF00D to addr 0x20 (previously 32'h0); assert Reset_n=0 while in WAIT; release; load addr 0x20.
  - Required: outputs 0 immediately on assertion; no Mem_done before the reload; the load returns 32'h0.
- WAIT_CYCLES=0 instance: word load completes with Mem_done high after E1; Mem_busy high for exactly 2 cycles.
